// File: rtl/bit_serializer.sv
// Word-to-bit serializer: a DEPTH-entry FIFO of WIDTH-bit words feeding a shift
// stage that emits one bit per clock, back-to-back across words, freezable by Hold.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_Valid,
  input  logic [WIDTH-1:0] In_Word,
  output logic             In_Ready,
  input  logic             Hold,
  output logic             Out_Data,
  output logic             Out_Valid,
  output logic             Busy,
  output logic             state_dbg
);

  // Handshake: a word transfers on a rising edge where In_Valid && In_Ready;
  // In_Valid may be held with a stable word until In_Ready accepts it.

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] head;
  logic             out_data_q, out_valid_q;
  logic             push, pop, last_bit;

  // Maps a bit index (0 = first emitted) onto a word bit position.
  function automatic logic [IW-1:0] bit_pos(input logic [IW-1:0] i);
    return MSB_FIRST ? (LAST - i) : i;
  endfunction

  assign head      = mem[rd_ptr];
  assign In_Ready  = (count != FULL);
  assign push      = In_Valid && In_Ready;
  assign last_bit  = (idx == LAST);
  // A pop happens only when the shift stage is free or finishing its last bit.
  assign pop       = !Hold && (count != '0) && ((state == IDLE) || last_bit);
  assign Out_Data  = out_data_q;
  assign Out_Valid = out_valid_q;
  assign Busy      = (count != '0) || (state == SHIFT);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= In_Word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      idx         <= '0;
      shreg       <= '0;
      out_data_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (pop) begin
        shreg       <= head;
        idx         <= '0;
        out_data_q  <= head[bit_pos('0)];
        out_valid_q <= 1'b1;
        state       <= SHIFT;
      end else if (!Hold && state == SHIFT) begin
        if (last_bit) begin
          // Out_Data keeps the last emitted bit while idle.
          out_valid_q <= 1'b0;
          state       <= IDLE;
        end else begin
          idx        <= idx + 1'b1;
          out_data_q <= shreg[bit_pos(idx + 1'b1)];
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: table-driven single-word vectors on an
// MSB-first and an LSB-first instance, plus hand-written multi-cycle sequences.
module tb_bit_serializer;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [7:0] in_word;
  logic hold;
  logic m_ready, m_data, m_valid, m_busy, m_state;
  logic l_ready, l_data, l_valid, l_busy, l_state;

  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] word;
    bit         lsb;
    logic [7:0] stream;   // stream[7] is the first bit expected on the wire
  } vec_t;

  vec_t vecs[5];

  bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Word(in_word),
    .In_Ready(m_ready), .Hold(hold), .Out_Data(m_data), .Out_Valid(m_valid),
    .Busy(m_busy), .state_dbg(m_state)
  );

  bit_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Word(in_word),
    .In_Ready(l_ready), .Hold(hold), .Out_Data(l_data), .Out_Valid(l_valid),
    .Busy(l_busy), .state_dbg(l_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Driver: push one word, then watch it serialize on the chosen instance.
  task automatic run_word(input logic [7:0] word, input bit lsb, input logic [7:0] stream);
    in_valid = 1'b1;
    in_word  = word;
    tick();
    in_valid = 1'b0;
    check("pre_pop_valid", lsb ? l_valid : m_valid, 0);
    check("pre_pop_busy", lsb ? l_busy : m_busy, 1);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("word_valid", lsb ? l_valid : m_valid, 1);
      check("word_bit", lsb ? l_data : m_data, stream[7-k]);
    end
    tick();
    check("post_valid", lsb ? l_valid : m_valid, 0);
    check("post_busy", lsb ? l_busy : m_busy, 0);
    check("post_hold_bit", lsb ? l_data : m_data, stream[0]);
  endtask

  task automatic expect_bit(input string name);
    logic [0:0] b;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s actual=queue_empty expected=bit", name);
    end else begin
      b = exp_q.pop_front();
      check({name, "_valid"}, m_valid, 1);
      check(name, m_data, b);
    end
  endtask

  initial begin
    logic [15:0] b2b;
    logic [7:0]  w;

    vecs[0] = '{8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{8'h80, 1'b1, 8'h01};
    vecs[2] = '{8'h0F, 1'b1, 8'hF0};
    vecs[3] = '{8'h12, 1'b1, 8'h48};
    vecs[4] = '{8'h3C, 1'b0, 8'h3C};

    rst = 1'b0; in_valid = 1'b0; in_word = 8'h00; hold = 1'b0;
    #2;
    check("rst_valid", m_valid, 0);
    check("rst_busy", m_busy, 0);
    check("rst_ready", m_ready, 1);
    check("rst_data", m_data, 0);
    check("rst_state", m_state, 0);
    in_valid = 1'b1; in_word = 8'hFF;   // pushes must be ignored in reset
    tick(); tick();
    check("rst_push_ignored_busy", m_busy, 0);
    check("rst_push_ignored_valid", m_valid, 0);
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick();
    check("post_rst_valid", m_valid, 0);
    check("post_rst_busy", m_busy, 0);

    for (int i = 0; i < 5; i++) run_word(vecs[i].word, vecs[i].lsb, vecs[i].stream);

    // Back-to-back: 16 contiguous bits
    b2b = 16'b0101_0101_1110_0000;
    for (int i = 15; i >= 0; i--) exp_q.push_back(b2b[i]);
    in_valid = 1'b1; in_word = 8'h55;
    tick();
    in_word = 8'hE0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_bit("b2b_bit");
      tick();
    end
    check("b2b_end_valid", m_valid, 0);
    check("b2b_end_busy", m_busy, 0);

    // Full FIFO / backpressure under Hold
    hold = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_word = 8'(i);
      check("full_ready_before_push", m_ready, 1);
      tick();
    end
    in_word = 8'h05;
    check("full_ready_low", m_ready, 0);
    tick(); tick();
    check("full_ready_stalled", m_ready, 0);
    check("full_held_valid", m_valid, 0);
    check("full_busy", m_busy, 1);
    for (int i = 1; i <= 5; i++) begin
      w = 8'(i);
      for (int b = 7; b >= 0; b--) exp_q.push_back(w[b]);
    end
    hold = 1'b0;
    tick();
    check("full_ready_after_pop", m_ready, 1);
    for (int i = 0; i < 40; i++) begin
      if (i == 1) in_valid = 1'b0;
      expect_bit("full_order_bit");
      tick();
    end
    check("full_end_valid", m_valid, 0);
    check("full_end_busy", m_busy, 0);
    check("full_end_queue", exp_q.size(), 0);

    // Hold mid-word on 8'hF0
    in_valid = 1'b1; in_word = 8'hF0;
    tick();
    in_valid = 1'b0;
    tick();
    check("hold_b0", m_data, 1);
    tick();
    check("hold_b1", m_data, 1);
    tick();
    check("hold_b2", m_data, 1);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_frozen_valid", m_valid, 1);
      check("hold_frozen_bit", m_data, 1);
    end
    hold = 1'b0;
    w = 8'hF0;
    for (int k = 3; k < 8; k++) begin
      tick();
      check("hold_rest_valid", m_valid, 1);
      check("hold_rest_bit", m_data, w[7-k]);
    end
    tick();
    check("hold_end_valid", m_valid, 0);

    // Reset mid-word with two words queued
    in_valid = 1'b1; in_word = 8'hAA;
    tick();
    in_word = 8'h11;
    tick();
    in_word = 8'h22;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("mid_bit4_valid", m_valid, 1);
    check("mid_bit4_data", m_data, 0);
    check("mid_queued_busy", m_busy, 1);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_busy", m_busy, 0);
    check("async_rst_ready", m_ready, 1);
    in_valid = 1'b1; in_word = 8'h77;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_stale_valid", m_valid, 0);
      check("no_stale_busy", m_busy, 0);
    end
    run_word(8'hC3, 1'b0, 8'b1100_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the Mealy sequence detector. Accepts WIDTH-bit words over a valid/ready handshake, buffers them in a DEPTH-entry FIFO, and shifts them out one bit per clock on `Out_Data`, which drives the detector's 1-bit `In_Data`. Consecutive words stream back-to-back with no bubble cycles. A `Hold` input freezes the bit stream without losing data.

## Interface
- `WIDTH`, default 8: word width in bits, ≥2.
- `DEPTH`, default 4: FIFO entries, power of two, ≥2.
- `MSB_FIRST`, default 1: 1 emits bit WIDTH-1 first, 0 emits bit 0 first.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `In_Valid`  in  1  `In_Word` holds a word to accept.
- `In_Word`  in  WIDTH  word to serialize.
- `In_Ready`  out  1  FIFO can accept a word this cycle.
- `Hold`  in  1  freeze shifting while high.
- `Out_Data`  out  1  current serial bit; connects to the detector's `In_Data`.
- `Out_Valid`  out  1  `Out_Data` is a live bit of a word.
- `Busy`  out  1  FIFO non-empty or a word is in flight.

## Operation
- **Push:** a word is written when `In_Valid && In_Ready` at a rising edge.
  - `In_Ready` = (count != DEPTH), combinational.
  - A push while full is impossible, so words are never overwritten.
- **FIFO:** circular buffer with log2(DEPTH)-bit read/write pointers and a log2(DEPTH)+1-bit count.
  - Pointers wrap from DEPTH-1 to 0.
  - A push and pop on the same edge leave count unchanged.
- **FSM, two states:**
  - IDLE: no word in flight; `Out_Valid`=0.
    - If the FIFO is non-empty and `Hold`=0, pop the head into the shift register, clear bit index to 0, go to SHIFT.
  - SHIFT: `Out_Valid`=1; `Out_Data` = shift-register bit at the current index, direction set by `MSB_FIRST`.
    - Each edge with `Hold`=0 increments the index.
    - On the edge that ends bit WIDTH-1: if the FIFO is non-empty, pop the next word and restart at index 0 in SHIFT (no gap). Otherwise go to IDLE.
  - `Hold`=1 in either state: no state, index, shift-register or pop change.
    - `Out_Data` and `Out_Valid` keep their values.
    - Pushes still proceed.
- `Busy` = (count != 0) || (state == SHIFT).
- **Output source:** `Out_Data` comes from a register, not from `In_Word`. In IDLE it holds the last emitted bit, or 0 after reset.

## Timing
- **Reset (rst=0), asynchronous:**
  - state=IDLE, pointers=0, count=0, index=0, shift register=0.
  - `Out_Data`=0, `Out_Valid`=0, `Busy`=0.
  - `In_Ready`=1 (count=0), but pushes are ignored while rst=0.
- Reset mid-word discards the in-flight word and all FIFO contents. The first valid bit after release comes only from a new push.
- **Latency:**
  - Word pushed at edge N into an empty, idle block is popped at edge N+1.
  - Its first bit is visible after edge N+1; its last bit after edge N+WIDTH.
  - `Out_Valid` is high for exactly WIDTH cycles per word when `Hold`=0.
- **Back-to-back streaming:** bit 0 of word k+1 follows bit WIDTH-1 of word k on the next cycle.
- **Full FIFO:** `In_Ready` drops in the same cycle count reaches DEPTH. It rises in the cycle after a pop edge.
- **Hold:** takes effect at the next edge; bit cells are stretched by the number of held cycles.

## Test plan
- **Single word:** reset, push 8'hA5 with MSB_FIRST=1 → `Out_Data` = 1,0,1,0,0,1,0,1 over 8 cycles. `Out_Valid` is high exactly those cycles, starting after the edge following the push. `Busy` then drops to 0.
- **Back-to-back:** push 8'h55 then 8'hE0 on consecutive cycles → 16 continuous valid bits 0,1,0,1,0,1,0,1,1,1,1,0,0,0,0,0, with no `Out_Valid` gap.
- **Full/backpressure:** hold `Out_Data` consumption with `Hold`=1, push words 8'h01..8'h05 with `In_Valid` held high.
  - Pushes 1–4 are accepted; `In_Ready`=0 after the 4th, and the 5th is stalled.
  - Release `Hold` → words emerge in order 01,02,03,04,05.
- **LSB-first:** with MSB_FIRST=0, push 8'h80 → seven 0s then 1.
- **Hold mid-word:** assert `Hold` for 3 cycles after the 3rd bit of 8'hF0 → `Out_Data`/`Out_Valid` are frozen 3 extra cycles, and the remaining bits are correct and contiguous.
- **Reset mid-operation:** pull rst low during bit 4 of a word with 2 words queued.
  - `Out_Valid`=0 and `Busy`=0 immediately, without waiting for a clock edge.
  - After release, no stale bits appear. A fresh push of 8'hC3 emits 1,1,0,0,0,0,1,1.
